// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// APB requester state encoding and the responder lane-mode select value.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Responder returns the raw 32-bit word; lane handling is done here.
    localparam logic [2:0] SEL_MOD_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

endpackage

// File: rtl/lsu_apb_requester_if.sv
// APB link between the LSU requester and the data-memory responder.
interface lsu_apb_requester_if #(
    parameter int ADDR_W = 11
);

    logic [ADDR_W-1:0] paddr_o;
    logic              psel_o;
    logic              penable_o;
    logic              pwrite_o;
    logic [31:0]       pwdata_o;
    logic [3:0]        pstrb_o;
    logic [2:0]        sel_mod_o;
    logic [31:0]       prdata_i;
    logic              pready_i;

    modport master (
        output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o, sel_mod_o,
        input  prdata_i, pready_i
    );

    modport slave (
        input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o, sel_mod_o,
        output prdata_i, pready_i
    );

endinterface

// File: rtl/lsu_apb_requester_lane_align.sv
// Combinational lane logic: request legality, store strobes/replicated data,
// and load lane extraction with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic        req_we,
    input  logic [1:0]  req_addr_lo,
    input  logic        req_addr_oor,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        req_legal,
    output logic [3:0]  wr_strb,
    output logic [31:0] wr_data,
    input  logic [1:0]  rd_addr_lo,
    input  logic [2:0]  rd_funct3,
    input  logic [31:0] rd_word,
    output logic [31:0] rd_data
);

    logic [31:0] rd_lane;

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        req_legal = !req_addr_oor;
        case (req_funct3)
            F3_B:    ;
            F3_H:    if (req_addr_lo[0]) req_legal = 1'b0;
            F3_W:    if (req_addr_lo != 2'b00) req_legal = 1'b0;
            F3_BU:   if (req_we) req_legal = 1'b0;
            F3_HU:   if (req_we || req_addr_lo[0]) req_legal = 1'b0;
            default: req_legal = 1'b0;
        endcase
    end

    always_comb begin
        wr_strb = 4'b0000;
        wr_data = 32'h0;
        if (req_we) begin
            case (req_funct3)
                F3_B: begin
                    wr_strb = 4'b0001 << req_addr_lo;
                    wr_data = {4{req_wdata[7:0]}};
                end
                F3_H: begin
                    wr_strb = 4'b0011 << {req_addr_lo[1], 1'b0};
                    wr_data = {2{req_wdata[15:0]}};
                end
                F3_W: begin
                    wr_strb = 4'b1111;
                    wr_data = req_wdata;
                end
                default: ;
            endcase
        end
    end

    assign rd_lane = rd_word >> {rd_addr_lo, 3'b000};

    always_comb begin
        rd_data = rd_lane;
        case (rd_funct3)
            F3_B:    rd_data = {{24{rd_lane[7]}}, rd_lane[7:0]};
            F3_H:    rd_data = {{16{rd_lane[15]}}, rd_lane[15:0]};
            F3_BU:   rd_data = {24'h0, rd_lane[7:0]};
            F3_HU:   rd_data = {16'h0, rd_lane[15:0]};
            default: rd_data = rd_lane;
        endcase
    end

endmodule

// File: rtl/lsu_apb_requester.sv
// APB requester for the MEM stage: one load/store per request becomes one
// SETUP+ACCESS transfer; illegal requests are answered without bus traffic.
module lsu_apb_requester
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [31:0]         req_addr_i,
    input  logic [31:0]         req_wdata_i,
    input  logic [2:0]          req_funct3_i,
    output logic                rsp_valid_o,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_err_o,
    lsu_apb_requester_if.master apb
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    apb_state_e        state_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic [ADDR_W-1:0] paddr_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [31:0]       pwdata_q;
    logic [3:0]        pstrb_q;
    logic [1:0]        rd_addr_lo_q;
    logic [2:0]        rd_funct3_q;
    logic [TMO_W-1:0]  tmo_cnt_q;

    logic              addr_oor;
    logic              req_legal;
    logic [3:0]        wr_strb;
    logic [31:0]       wr_data;
    logic [31:0]       rd_data;

    assign addr_oor = |req_addr_i[31:ADDR_W];

    lsu_lane_align u_lane_align (
        .req_we       (req_we_i),
        .req_addr_lo  (req_addr_i[1:0]),
        .req_addr_oor (addr_oor),
        .req_funct3   (req_funct3_i),
        .req_wdata    (req_wdata_i),
        .req_legal    (req_legal),
        .wr_strb      (wr_strb),
        .wr_data      (wr_data),
        .rd_addr_lo   (rd_addr_lo_q),
        .rd_funct3    (rd_funct3_q),
        .rd_word      (apb.prdata_i),
        .rd_data      (rd_data)
    );

    // NOTE: reset is synchronous, so rst_ni is sampled only at the clock edge
    // and stays out of the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            rsp_err_q    <= 1'b0;
            paddr_q      <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= 32'h0;
            pstrb_q      <= 4'b0000;
            rd_addr_lo_q <= 2'b00;
            rd_funct3_q  <= 3'b000;
            tmo_cnt_q    <= '0;
        end else begin
            // NOTE: all state updates use <= so every register samples the
            // pre-edge values, regardless of statement order.
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        if (req_legal) begin
                            state_q      <= SETUP;
                            ready_q      <= 1'b0;
                            psel_q       <= 1'b1;
                            paddr_q      <= {req_addr_i[ADDR_W-1:2], 2'b00};
                            pwrite_q     <= req_we_i;
                            pwdata_q     <= wr_data;
                            pstrb_q      <= wr_strb;
                            rd_addr_lo_q <= req_addr_i[1:0];
                            rd_funct3_q  <= req_funct3_i;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                    tmo_cnt_q <= '0;
                end
                ACCESS: begin
                    // Completion and timeout abort share the return to an idle bus.
                    if (apb.pready_i || tmo_cnt_q == TMO_LAST) begin
                        state_q     <= IDLE;
                        ready_q     <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        pwrite_q    <= 1'b0;
                        paddr_q     <= '0;
                        pwdata_q    <= 32'h0;
                        pstrb_q     <= 4'b0000;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= !apb.pready_i;
                        rsp_rdata_q <= (apb.pready_i && !pwrite_q) ? rd_data : 32'h0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o   = ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign apb.paddr_o   = paddr_q;
    assign apb.psel_o    = psel_q;
    assign apb.penable_o = penable_q;
    assign apb.pwrite_o  = pwrite_q;
    assign apb.pwdata_o  = pwdata_q;
    assign apb.pstrb_o   = pstrb_q;
    assign apb.sel_mod_o = SEL_MOD_WORD;

endmodule

// File: tb/tb_lsu_apb_requester.sv
// Self-checking bench for lsu_apb_requester: scoreboarded responses plus
// per-phase APB bus checks for loads, stores, illegal requests and timeouts.
module tb_lsu_apb_requester;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_funct3 = 3'b000;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] prdata = 32'h0;
    logic        pready = 1'b0;

    int   n_vec = 0;
    int   n_err = 0;
    rsp_t exp_q[$];

    lsu_apb_requester_if #(.ADDR_W(11)) apb ();

    assign apb.prdata_i = prdata;
    assign apb.pready_i = pready;

    lsu_apb_requester #(.ADDR_W(11), .TIMEOUT_CYC(15)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_funct3_i (req_funct3),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .apb          (apb)
    );

    always #5 clk_i = ~clk_i;

    // {psel, penable, pwrite, paddr, pstrb, pwdata}
    function automatic logic [49:0] bus_snap();
        return {apb.psel_o, apb.penable_o, apb.pwrite_o, apb.paddr_o, apb.pstrb_o, apb.pwdata_o};
    endfunction

    // Response scoreboard: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk_i) begin
        if (rsp_valid_o === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 err=%b rdata=%h, required no response",
                         rsp_err_o, rsp_rdata_o);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                if ({rsp_err_o, rsp_rdata_o} !== {e.err, e.rdata}) begin
                    n_err++;
                    $display("FAIL rsp: got err=%b rdata=%h, required err=%b rdata=%h",
                             rsp_err_o, rsp_rdata_o, e.err, e.rdata);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] f3, output bit ok);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got req_ready=%b, required 1 within 20 cycles", req_ready_o);
        end
        @(negedge clk_i);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk_i);
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s rsp_missing: got %0d pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3, input logic [31:0] rd,
                           input int waits, input logic [3:0] exp_strb,
                           input logic [31:0] exp_pwdata, input logic [31:0] exp_rdata);
        logic [49:0] exp_setup;
        logic [49:0] exp_access;
        logic [10:0] exp_paddr;
        bit ok;
        exp_paddr  = addr[10:0] & 11'h7FC;
        exp_setup  = {1'b1, 1'b0, we, exp_paddr, exp_strb, exp_pwdata};
        exp_access = {1'b1, 1'b1, we, exp_paddr, exp_strb, exp_pwdata};
        pready = 1'b0;
        prdata = 32'h0;
        exp_q.push_back('{err: 1'b0, rdata: exp_rdata});
        send_req(we, addr, wdata, f3, ok);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        n_vec++;
        if ({bus_snap(), req_ready_o} !== {exp_setup, 1'b0}) begin
            n_err++;
            $display("FAIL %s setup: got bus=%h ready=%b, required bus=%h ready=0",
                     name, bus_snap(), req_ready_o, exp_setup);
        end
        @(negedge clk_i);
        n_vec++;
        if (bus_snap() !== exp_access) begin
            n_err++;
            $display("FAIL %s access: got bus=%h, required %h", name, bus_snap(), exp_access);
        end
        for (int i = 0; i < waits; i++) begin
            @(negedge clk_i);
            n_vec++;
            if ({bus_snap(), rsp_valid_o} !== {exp_access, 1'b0}) begin
                n_err++;
                $display("FAIL %s wait%0d: got bus=%h rsp_valid=%b, required bus=%h rsp_valid=0",
                         name, i, bus_snap(), rsp_valid_o, exp_access);
            end
        end
        pready = 1'b1;
        prdata = rd;
        @(negedge clk_i);
        pready = 1'b0;
        prdata = 32'h0;
        n_vec++;
        if ({bus_snap(), req_ready_o, rsp_valid_o} !== {50'h0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL %s done: got bus=%h ready=%b rsp_valid=%b, required bus=0 ready=1 rsp_valid=1",
                     name, bus_snap(), req_ready_o, rsp_valid_o);
        end
        wait_drain(name);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        n_vec++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, bus_snap(), apb.sel_mod_o} !==
            {1'b1, 1'b0, 1'b0, 32'h0, 50'h0, 3'b010}) begin
            n_err++;
            $display("FAIL reset: got ready=%b rsp_valid=%b err=%b rdata=%h bus=%h sel_mod=%b, required 1 0 0 0 0 010",
                     req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, bus_snap(), apb.sel_mod_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_stores();
        run_txn("sw_104", 1'b1, 32'h104, 32'hDEADBEEF, 3'b010, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 32'h0);
        run_txn("sb_103", 1'b1, 32'h103, 32'h000000A5, 3'b000, 32'h0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0);
        run_txn("sh_106", 1'b1, 32'h106, 32'h1234BEEF, 3'b001, 32'h0, 0, 4'b1100, 32'hBEEFBEEF, 32'h0);
    endtask

    task automatic test_loads();
        run_txn("lb_103",  1'b0, 32'h103, 32'h0, 3'b000, 32'hA5000000, 0, 4'b0000, 32'h0, 32'hFFFFFFA5);
        run_txn("lbu_103", 1'b0, 32'h103, 32'h0, 3'b100, 32'hA5000000, 0, 4'b0000, 32'h0, 32'h000000A5);
        run_txn("lh_102",  1'b0, 32'h102, 32'h0, 3'b001, 32'h80010000, 0, 4'b0000, 32'h0, 32'hFFFF8001);
        run_txn("lhu_102", 1'b0, 32'h102, 32'h0, 3'b101, 32'h80010000, 0, 4'b0000, 32'h0, 32'h00008001);
        run_txn("lw_100",  1'b0, 32'h100, 32'h0, 3'b010, 32'h12345678, 0, 4'b0000, 32'h0, 32'h12345678);
        run_txn("lw_7fc",  1'b0, 32'h7FC, 32'h0, 3'b010, 32'h0BADF00D, 0, 4'b0000, 32'h0, 32'h0BADF00D);
    endtask

    task automatic test_illegal();
        logic        t_we[5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] t_addr[5] = '{32'h106, 32'h101, 32'h100, 32'h800, 32'h100};
        logic [2:0]  t_f3[5]   = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{err: 1'b1, rdata: 32'h0});
            req_valid  = 1'b1;
            req_we     = t_we[i];
            req_addr   = t_addr[i];
            req_wdata  = 32'hFFFFFFFF;
            req_funct3 = t_f3[i];
            @(negedge clk_i);
            req_valid = 1'b0;
            n_vec++;
            if ({bus_snap(), req_ready_o, rsp_valid_o} !== {50'h0, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL illegal%0d: got bus=%h ready=%b rsp_valid=%b, required bus=0 ready=1 rsp_valid=1",
                         i, bus_snap(), req_ready_o, rsp_valid_o);
            end
            wait_drain("illegal");
        end
    endtask

    task automatic test_wait_states();
        run_txn("lw_wait3", 1'b0, 32'h200, 32'h0, 3'b010, 32'hCAFEF00D, 3, 4'b0000, 32'h0, 32'hCAFEF00D);
        run_txn("sb_wait2", 1'b1, 32'h201, 32'h0000003C, 3'b000, 32'h0, 2, 4'b0010, 32'h3C3C3C3C, 32'h0);
    endtask

    task automatic test_timeout();
        bit ok;
        pready = 1'b0;
        exp_q.push_back('{err: 1'b1, rdata: 32'h0});
        send_req(1'b0, 32'h300, 32'h0, 3'b010, ok);
        @(negedge clk_i);
        repeat (14) @(negedge clk_i);
        n_vec++;
        if ({apb.psel_o, apb.penable_o, rsp_valid_o} !== 3'b110) begin
            n_err++;
            $display("FAIL timeout_hold: got psel=%b penable=%b rsp_valid=%b after 14 waits, required 1 1 0",
                     apb.psel_o, apb.penable_o, rsp_valid_o);
        end
        @(negedge clk_i);
        n_vec++;
        if ({bus_snap(), req_ready_o, rsp_valid_o} !== {50'h0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL timeout_abort: got bus=%h ready=%b rsp_valid=%b, required bus=0 ready=1 rsp_valid=1",
                     bus_snap(), req_ready_o, rsp_valid_o);
        end
        wait_drain("timeout");
    endtask

    task automatic test_reset_in_access();
        bit ok;
        pready = 1'b0;
        send_req(1'b1, 32'h120, 32'h55AA55AA, 3'b010, ok);
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        n_vec++;
        if ({bus_snap(), req_ready_o, rsp_valid_o} !== {50'h0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_access: got bus=%h ready=%b rsp_valid=%b, required bus=0 ready=1 rsp_valid=0",
                     bus_snap(), req_ready_o, rsp_valid_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_txn("after_reset", 1'b0, 32'h120, 32'h0, 3'b001, 32'h7FFF1234, 0, 4'b0000, 32'h0, 32'h00001234);
    endtask

    task automatic test_back_to_back();
        pready = 1'b1;
        prdata = 32'h11223344;
        exp_q.push_back('{err: 1'b0, rdata: 32'h11223344});
        exp_q.push_back('{err: 1'b0, rdata: 32'h00000033});
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h010;
        req_funct3 = 3'b010;
        @(negedge clk_i);
        req_addr   = 32'h015;
        req_funct3 = 3'b100;
        n_vec++;
        if (req_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_busy_c1: got ready=%b, required 0", req_ready_o);
        end
        @(negedge clk_i);
        n_vec++;
        if ({req_ready_o, apb.psel_o, apb.penable_o, apb.paddr_o} !== {1'b0, 1'b1, 1'b1, 11'h010}) begin
            n_err++;
            $display("FAIL b2b_c2: got ready=%b psel=%b penable=%b paddr=%h, required 0 1 1 010",
                     req_ready_o, apb.psel_o, apb.penable_o, apb.paddr_o);
        end
        @(negedge clk_i);
        n_vec++;
        if ({req_ready_o, apb.psel_o} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_c3: got ready=%b psel=%b, required 1 0", req_ready_o, apb.psel_o);
        end
        @(negedge clk_i);
        req_valid = 1'b0;
        n_vec++;
        if (bus_snap() !== {1'b1, 1'b0, 1'b0, 11'h014, 4'b0000, 32'h0}) begin
            n_err++;
            $display("FAIL b2b_second_setup: got bus=%h, required %h",
                     bus_snap(), {1'b1, 1'b0, 1'b0, 11'h014, 4'b0000, 32'h0});
        end
        repeat (2) @(negedge clk_i);
        pready = 1'b0;
        prdata = 32'h0;
        wait_drain("b2b");
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_illegal();
        test_wait_states();
        test_timeout();
        test_reset_in_access();
        test_back_to_back();
        repeat (3) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
